// File: rtl/power_seq_pkg.sv
// Shared types and helpers for the power-stage follower: FSM state encoding,
// the widest supported enable chain, and the thermometer step used for ramping.
package power_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } state_e;

  localparam int MAX_STAGES = 16;

  // Stepping up shifts a 1 in at bit 0; stepping down drops the highest set bit.
  function automatic logic [MAX_STAGES-1:0] therm_step(input logic [MAX_STAGES-1:0] mask,
                                                       input logic                  up);
    if (up) begin
      return {mask[MAX_STAGES-2:0], 1'b1};
    end
    return {1'b0, mask[MAX_STAGES-1:1]};
  endfunction

endpackage

// File: rtl/power_stage_follower_stage_delay_counter.sv
// Inter-stage delay: reloadable down-counter, expire fires combinationally when count hits 0 while enabled.
// No backpressure; load has priority over counting.
module stage_delay_counter #(
  parameter int STAGE_DLY = 8,
  parameter int CNT_W     = $clog2(STAGE_DLY + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STAGE_DLY - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/power_stage_follower.sv
// Follows the sequencer's SEL level, ramping a thermometer chain of stage enables up or down one
// stage every STAGE_DLY cycles; all outputs registered, reversals take effect on the next cycle.
module power_stage_follower
  import power_seq_pkg::*;
#(
  parameter int N_STAGES  = 4,
  parameter int STAGE_DLY = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SEL,
  output logic [N_STAGES-1:0] EN,
  output logic                READY,
  output logic                OFF,
  output logic                BUSY
);

  localparam int CNT_W = $clog2(STAGE_DLY + 1);

  state_e                state_q, state_d;
  logic [N_STAGES-1:0]   en_q, en_d;
  logic                  ready_q, ready_d;
  logic                  off_q, off_d;
  logic                  busy_q, busy_d;
  logic                  load;
  logic                  cnt_en;
  logic                  expire;

  logic [MAX_STAGES-1:0] en_wide;
  logic [MAX_STAGES-1:0] up_w;
  logic [MAX_STAGES-1:0] dn_w;
  logic [N_STAGES-1:0]   up_mask;
  logic [N_STAGES-1:0]   dn_mask;
  logic                  unused_mask_bits;

  assign en_wide          = MAX_STAGES'(en_q);
  assign up_w             = therm_step(en_wide, 1'b1);
  assign dn_w             = therm_step(en_wide, 1'b0);
  assign up_mask          = up_w[N_STAGES-1:0];
  assign dn_mask          = dn_w[N_STAGES-1:0];
  assign unused_mask_bits = ^{up_w, dn_w};

  stage_delay_counter #(
    .STAGE_DLY (STAGE_DLY),
    .CNT_W     (CNT_W)
  ) u_dly (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .en     (cnt_en),
    .expire (expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      en_q    <= '0;
      ready_q <= 1'b0;
      off_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      off_q   <= off_d;
      busy_q  <= busy_d;
    end
  end

  // Any stage transition reloads the delay, so a reversal discards the pending countdown.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (SEL) begin
          en_d    = up_mask;
          load    = 1'b1;
          state_d = UP;
        end
      end
      UP: begin
        if (!SEL) begin
          en_d    = dn_mask;
          load    = 1'b1;
          state_d = (dn_mask == '0) ? IDLE : DOWN;
        end else if (expire) begin
          en_d    = up_mask;
          load    = 1'b1;
          state_d = (up_mask == '1) ? ON : UP;
        end
      end
      ON: begin
        if (!SEL) begin
          en_d    = dn_mask;
          load    = 1'b1;
          state_d = DOWN;
        end
      end
      DOWN: begin
        if (SEL) begin
          en_d    = up_mask;
          load    = 1'b1;
          state_d = (up_mask == '1) ? ON : UP;
        end else if (expire) begin
          en_d    = dn_mask;
          load    = 1'b1;
          state_d = (dn_mask == '0) ? IDLE : DOWN;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
      end
    endcase
  end

  always_comb begin
    ready_d = (state_d == ON);
    off_d   = (state_d == IDLE);
    busy_d  = (state_d == UP) || (state_d == DOWN);
    cnt_en  = (state_q == UP) || (state_q == DOWN);
  end

  assign EN    = en_q;
  assign READY = ready_q;
  assign OFF   = off_q;
  assign BUSY  = busy_q;

endmodule
